led_pwm_driver: RTL and testbench
=================================

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 195, giving clk cycles per PWM tick (50 MHz/195/256 ≈ 1 kHz PWM).
REQ-002 The block SHALL have parameter STEP, default 32, giving the level increment/decrement per up/down request in STEADY.
REQ-003 The block SHALL have parameter BREATHE_DIV, default 4, giving the number of PWM periods per 1-LSB level change in breathe mode.
REQ-004 The block SHALL have parameter RESET_LEVEL, default 128, giving the 8-bit brightness after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock, 50 MHz.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-007 The block SHALL have port up_pulse, input, 1 bit: a one-cycle brightness-up request (debounced key event).
REQ-008 The block SHALL have port down_pulse, input, 1 bit: a one-cycle brightness-down request.
REQ-009 The block SHALL have port mode_pulse, input, 1 bit: a one-cycle request to toggle between steady and breathe.
REQ-010 The block SHALL have port led, output, 1 bit: the registered PWM drive, where 1 means lit.
REQ-011 The block SHALL have port level, output, 8 bits: the current target brightness.
REQ-012 The block SHALL have port breathing, output, 1 bit: 1 when state is RISE or FALL.

Function
REQ-013 The prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick SHALL be asserted for the one cycle in which prescaler == PRESCALE-1.
REQ-014 On each tick, the 8-bit pwm_cnt SHALL increment, wrapping 255 -> 0; the cycle where pwm_cnt wraps SHALL be the period boundary.
REQ-015 duty_active SHALL load from level only at a period boundary; a level change mid-period SHALL NOT alter the current period.
REQ-016 led SHALL be registered as (pwm_cnt < duty_active), giving 1 cycle of latency from the counter.
REQ-017 At duty_active 0, led SHALL stay 0 for the whole period; at 255, led SHALL be 1 for 255 of 256 tick slots.
REQ-018 The state machine SHALL have exactly three states: STEADY, RISE, FALL.
REQ-019 In STEADY, up_pulse alone SHALL set level to min(level+STEP, 255), computed 9-bit and saturated.
REQ-020 In STEADY, down_pulse alone SHALL set level to max(level-STEP, 0), with no underflow wrap.
REQ-021 In STEADY, up_pulse and down_pulse in the same cycle SHALL leave level unchanged.
REQ-022 Level updates SHALL be visible on the level output on the cycle after the request.
REQ-023 mode_pulse in STEADY SHALL go to FALL if level == 255, else RISE; level SHALL be unchanged by the transition.
REQ-024 mode_pulse in RISE or FALL SHALL go to STEADY and freeze level at its current value.
REQ-025 When mode_pulse coincides with up_pulse or down_pulse, mode_pulse SHALL win and up/down SHALL be ignored that cycle.
REQ-026 In RISE or FALL, up_pulse and down_pulse SHALL be ignored.
REQ-027 In RISE or FALL, a breathe counter SHALL count period boundaries 0..BREATHE_DIV-1; when it wraps, RISE SHALL increment level by 1 and FALL SHALL decrement it by 1.
REQ-028 RISE SHALL switch to FALL in the same cycle level becomes 255; FALL SHALL switch to RISE in the same cycle level becomes 0; level SHALL never wrap.
REQ-029 The breathe counter SHALL clear on every entry into RISE from STEADY and on every entry into FALL from STEADY.
REQ-030 Request pulses longer than 1 cycle SHALL act once per high cycle; no edge detection is required.

Reset
REQ-031 While rst is high, regardless of clk: prescaler=0, pwm_cnt=0, breathe counter=0, state=STEADY, level=RESET_LEVEL, duty_active=RESET_LEVEL, led=0, breathing=0.
REQ-032 Reset asserted mid-period or mid-breathe SHALL abort immediately to the REQ-031 values.
REQ-033 After reset deasserts, the first clk edge SHALL begin a new PWM period with duty RESET_LEVEL.

Verification
REQ-034 The bench SHALL use PRESCALE=2, BREATHE_DIV=1, RESET_LEVEL=128 for every scenario below.
REQ-035 Scenario 1: release reset, observe 256 ticks -> led high for exactly 128 tick slots, level=128, breathing=0.
REQ-036 Scenario 2: from 128, 5 up_pulses -> level 160,192,224,255,255; then 9 down_pulses -> level reaches 0 and holds; led stays 0 after the next period boundary.
REQ-037 Scenario 3: up_pulse and down_pulse together -> level unchanged; up_pulse mid-period -> duty_active changes only at the next pwm_cnt wrap.
REQ-038 Scenario 4: level=255, mode_pulse -> FALL, breathing=1; level decrements 1 per period down to 0, then RISE; mode_pulse+up_pulse together -> STEADY with level frozen.
REQ-039 Scenario 5: assert rst mid-RISE at level 77 -> led=0, level=128, state STEADY immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - LED PWM driver with stepped brightness and breathe mode
// 256-slot PWM whose duty reloads only at period boundaries; steady/rise/fall level control.
module led_pwm_driver #(
  parameter int PRESCALE    = 195,
  parameter int STEP        = 32,
  parameter int BREATHE_DIV = 4,
  parameter int RESET_LEVEL = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       mode_pulse,
  output logic       led,
  output logic [7:0] level,
  output logic       breathing
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BREATHE_LAST  = BW'(BREATHE_DIV - 1);
  localparam logic [7:0]    RESET_LVL8    = 8'(RESET_LEVEL);
  localparam logic [8:0]    STEP9         = 9'(STEP);
  localparam logic [7:0]    STEP8         = 8'(STEP);

  typedef enum logic [1:0] {
    STEADY = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic          led_q, led_d;
  logic [BW-1:0] breathe_q, breathe_d;
  state_t        state_q, state_d;
  logic [7:0]    level_q, level_d;

  logic          tick;
  logic          boundary;
  logic [8:0]    sum9;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q <= '0;
      pwm_cnt_q   <= '0;
      duty_q      <= RESET_LVL8;
      led_q       <= 1'b0;
      breathe_q   <= '0;
      state_q     <= STEADY;
      level_q     <= RESET_LVL8;
    end else begin
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      led_q       <= led_d;
      breathe_q   <= breathe_d;
      state_q     <= state_d;
      level_q     <= level_d;
    end
  end

  // Duty is latched only when the counter wraps so a period is never split.
  always_comb begin
    tick        = (prescaler_q == PRESCALE_LAST);
    boundary    = tick && (pwm_cnt_q == 8'hFF);
    prescaler_d = tick ? '0 : prescaler_q + PW'(1);
    pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_d      = boundary ? level_q : duty_q;
    led_d       = (pwm_cnt_q < duty_q);
  end

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    breathe_d = breathe_q;
    sum9      = {1'b0, level_q} + STEP9;
    case (state_q)
      STEADY: begin
        if (mode_pulse) begin
          state_d   = (level_q == 8'hFF) ? FALL : RISE;
          breathe_d = '0;
        end else if (up_pulse && !down_pulse) begin
          level_d = sum9[8] ? 8'hFF : sum9[7:0];
        end else if (down_pulse && !up_pulse) begin
          level_d = ({1'b0, level_q} < STEP9) ? 8'h00 : level_q - STEP8;
        end
      end
      RISE, FALL: begin
        if (mode_pulse) begin
          state_d = STEADY;
        end else if (boundary) begin
          if (breathe_q == BREATHE_LAST) begin
            breathe_d = '0;
            // Direction flips on the same cycle the rail is reached.
            if (state_q == RISE) begin
              if (level_q >= 8'd254) begin
                level_d = 8'hFF;
                state_d = FALL;
              end else begin
                level_d = level_q + 8'd1;
              end
            end else begin
              if (level_q <= 8'd1) begin
                level_d = 8'h00;
                state_d = RISE;
              end else begin
                level_d = level_q - 8'd1;
              end
            end
          end else begin
            breathe_d = breathe_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = STEADY;
      end
    endcase
  end

  assign led       = led_q;
  assign level     = level_q;
  assign breathing = (state_q != STEADY);

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - scoreboard bench for led_pwm_driver
// Expectations are queued by the stimulus and retired by a separate monitor.
module tb_led_pwm_driver;

  logic       clk;
  logic       rst;
  logic       up_pulse;
  logic       down_pulse;
  logic       mode_pulse;
  logic       led;
  logic [7:0] level;
  logic       breathing;

  typedef struct {
    string name;
    int    kind;
    int    exp;
  } chk_t;

  chk_t exp_q[$];
  chk_t cur;
  event chk_ev;
  int   n_vec;
  int   n_bad;
  int   act;
  int   meas_cnt;
  int   cyc;
  int   wc;

  localparam int K_LEVEL = 0;
  localparam int K_BREATH = 1;
  localparam int K_LED = 2;
  localparam int K_WIN = 3;

  led_pwm_driver #(
    .PRESCALE(2),
    .STEP(32),
    .BREATHE_DIV(1),
    .RESET_LEVEL(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .up_pulse(up_pulse),
    .down_pulse(down_pulse),
    .mode_pulse(mode_pulse),
    .led(led),
    .level(level),
    .breathing(breathing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; a PWM period is 512 edges at PRESCALE=2.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        case (cur.kind)
          K_LEVEL:  act = int'(level);
          K_BREATH: act = int'(breathing);
          K_LED:    act = int'(led);
          default:  act = meas_cnt;
        endcase
        n_vec++;
        if (act != cur.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d, want %0d", cur.name, act, cur.exp);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int kind, input int exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    exp_q.push_back(c);
  endtask

  task automatic flush();
    int t;
    -> chk_ev;
    t = 0;
    while (exp_q.size() > 0 && t < 30) begin
      #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL flush_timeout: %0d checks pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse(input bit u, input bit d, input bit m);
    @(negedge clk);
    up_pulse = u;
    down_pulse = d;
    mode_pulse = m;
    @(negedge clk);
    up_pulse = 1'b0;
    down_pulse = 1'b0;
    mode_pulse = 1'b0;
  endtask

  task automatic wait_period_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % 512) != 1 && n < 1100);
  endtask

  task automatic measure(output int c);
    c = int'(led);
    repeat (511) begin
      @(negedge clk);
      c += int'(led);
    end
  endtask

  int up_exp[5]   = '{160, 192, 224, 255, 255};
  int down_exp[9] = '{223, 191, 159, 127, 95, 63, 31, 0, 0};
  int fall_up[5]  = '{128, 160, 192, 224, 255};
  int dn6_exp[6]  = '{222, 190, 158, 126, 94, 62};

  initial begin
    n_vec = 0;
    n_bad = 0;
    meas_cnt = 0;
    rst = 1'b1;
    up_pulse = 1'b0;
    down_pulse = 1'b0;
    mode_pulse = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_level", K_LEVEL, 128);
    check("rst_breathing", K_BREATH, 0);
    check("rst_led", K_LED, 0);
    flush();

    // Scenario 1: first period after reset runs at RESET_LEVEL.
    @(negedge clk);
    rst = 1'b0;
    wait_period_start();
    measure(wc);
    meas_cnt = wc;
    check("s1_window_128", K_WIN, 2 * 128);
    check("s1_level", K_LEVEL, 128);
    check("s1_breathing", K_BREATH, 0);
    flush();

    // Scenario 2: saturating steps up then down.
    for (int i = 0; i < 5; i++) begin
      pulse(1, 0, 0);
      check($sformatf("s2_up%0d", i), K_LEVEL, up_exp[i]);
      flush();
    end
    for (int i = 0; i < 9; i++) begin
      pulse(0, 1, 0);
      check($sformatf("s2_down%0d", i), K_LEVEL, down_exp[i]);
      flush();
    end
    wait_period_start();
    measure(wc);
    meas_cnt = wc;
    check("s2_window_0", K_WIN, 0);
    flush();

    // Scenario 3: mid-period change must wait for the next wrap.
    wait_period_start();
    fork
      measure(wc);
      begin
        repeat (19) @(negedge clk);
        pulse(1, 0, 0);
      end
    join
    meas_cnt = wc;
    check("s3_level_32", K_LEVEL, 32);
    check("s3_window_old_duty", K_WIN, 0);
    flush();
    wait_period_start();
    measure(wc);
    meas_cnt = wc;
    check("s3_window_new_duty", K_WIN, 2 * 32);
    flush();
    pulse(1, 1, 0);
    check("s3_up_down_same", K_LEVEL, 32);
    flush();
    @(negedge clk);
    up_pulse = 1'b1;
    repeat (2) @(negedge clk);
    up_pulse = 1'b0;
    check("s3_long_up", K_LEVEL, 96);
    flush();

    // Scenario 4: breathe from the top rail, overrides, and the top turnaround.
    for (int i = 0; i < 5; i++) begin
      pulse(1, 0, 0);
      check($sformatf("s4_up%0d", i), K_LEVEL, fall_up[i]);
      flush();
    end
    wait_period_start();
    pulse(0, 1, 1);
    check("s4_fall_level", K_LEVEL, 255);
    check("s4_fall_breathing", K_BREATH, 1);
    flush();
    wait_period_start();
    check("s4_fall_254", K_LEVEL, 254);
    flush();
    wait_period_start();
    pulse(1, 0, 0);
    check("s4_fall_up_ignored", K_LEVEL, 253);
    check("s4_fall_still_breathing", K_BREATH, 1);
    flush();
    pulse(1, 0, 1);
    check("s4_freeze_level", K_LEVEL, 253);
    check("s4_freeze_breathing", K_BREATH, 0);
    flush();
    wait_period_start();
    check("s4_frozen_after_period", K_LEVEL, 253);
    flush();
    pulse(0, 0, 1);
    check("s4_rise_breathing", K_BREATH, 1);
    check("s4_rise_level", K_LEVEL, 253);
    flush();
    wait_period_start();
    check("s4_rise_254", K_LEVEL, 254);
    flush();
    wait_period_start();
    check("s4_rise_255", K_LEVEL, 255);
    flush();
    wait_period_start();
    check("s4_turn_to_fall", K_LEVEL, 254);
    check("s4_turn_breathing", K_BREATH, 1);
    flush();

    // Scenario 5: async reset in the middle of a RISE at level 77.
    pulse(0, 0, 1);
    check("s5_steady_254", K_LEVEL, 254);
    flush();
    for (int i = 0; i < 6; i++) begin
      pulse(0, 1, 0);
      check($sformatf("s5_down%0d", i), K_LEVEL, dn6_exp[i]);
      flush();
    end
    pulse(0, 0, 1);
    check("s5_rise_breathing", K_BREATH, 1);
    flush();
    repeat (15) wait_period_start();
    check("s5_level_77", K_LEVEL, 77);
    flush();
    repeat (20) @(negedge clk);
    check("s5_led_lit", K_LED, 1);
    flush();
    rst = 1'b1;
    #1;
    check("s5_rst_led", K_LED, 0);
    check("s5_rst_level", K_LEVEL, 128);
    check("s5_rst_breathing", K_BREATH, 0);
    flush();

    @(negedge clk);
    rst = 1'b0;
    wait_period_start();
    measure(wc);
    meas_cnt = wc;
    check("s5_post_rst_window", K_WIN, 2 * 128);
    check("s5_post_rst_level", K_LEVEL, 128);
    flush();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
